// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, credit-limited requests, in-order response queue to decode.
// Latency: request n -> response n+1 -> o_valid n+2 (1-cycle memory). Decode stall holds the head; credits stop requests.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_target,
  input  logic        i_hlt,
  output logic        o_imReq,
  output logic [15:0] o_imAddr,
  input  logic        i_imRdy,
  input  logic        i_imValid,
  input  logic [15:0] i_imData,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic [15:0] o_pcNext,
  output logic        o_valid,
  output logic        o_halted
);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  logic [15:0]   fpc;
  logic [15:0]   tagPc;
  logic [CW-1:0] dropCnt, qCount, inflight;
  logic          halted;
  logic          issue, consume, haltNow, discard, qPush, qClr;
  entry_t        head, qIn;

  assign o_valid  = (qCount != '0);
  // Queued plus in-flight words share one credit pool, so the queue cannot overflow.
  assign o_imReq  = i_nRst & ~halted & ~i_redirect &
                    (({1'b0, qCount} + {1'b0, inflight}) < (CW + 1)'(QDEPTH));
  assign o_imAddr = fpc;
  assign o_halted = halted;

  assign issue   = o_imReq & i_imRdy;
  assign consume = o_valid & ~i_stall;
  assign haltNow = i_hlt & consume & ~i_redirect;
  assign discard = (dropCnt != '0) | halted | haltNow | i_redirect;
  assign qPush   = i_imValid & ~discard;
  assign qClr    = i_redirect | haltNow;
  assign qIn     = '{instr: i_imData, pc: tagPc};

  assign o_instr  = o_valid ? head.instr : 16'h0000;
  assign o_pc     = o_valid ? head.pc : fpc;
  assign o_pcNext = o_pc + 16'd1;

  fifo #(.W(16), .DEPTH(QDEPTH)) tagFifo (
    .clk   (i_clk),
    .nRst  (i_nRst),
    .clr   (1'b0),
    .wrVld (issue),
    .wrDat (fpc),
    .rdRdy (i_imValid),
    .rdDat (tagPc),
    .count (inflight)
  );

  fifo #(.W($bits(entry_t)), .DEPTH(QDEPTH)) instrQueue (
    .clk   (i_clk),
    .nRst  (i_nRst),
    .clr   (qClr),
    .wrVld (qPush),
    .wrDat (qIn),
    .rdRdy (consume),
    .rdDat (head),
    .count (qCount)
  );

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      fpc     <= RESET_PC;
      dropCnt <= '0;
      halted  <= 1'b0;
    end else if (i_redirect) begin
      fpc     <= i_target;
      // Everything still outstanding after this cycle is wrong-path.
      dropCnt <= inflight - CW'(i_imValid);
      halted  <= 1'b0;
    end else begin
      if (issue)
        fpc <= fpc + 16'd1;
      if (i_imValid && dropCnt != '0)
        dropCnt <= dropCnt - 1'b1;
      if (haltNow)
        halted <= 1'b1;
    end
  end
endmodule

// Generic in-order FIFO with synchronous clear; the user guarantees no push when full or pop when empty.
// Zero-latency head on rdDat; clear has priority over push and pop.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       clr,
  input  logic                       wrVld,
  input  logic [W-1:0]               wrDat,
  input  logic                       rdRdy,
  output logic [W-1:0]               rdDat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdDat = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrVld && !clr)
      mem[wrPtr] <= wrDat;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrVld)
        wrPtr <= nxt(wrPtr);
      if (rdRdy)
        rdPtr <= nxt(rdPtr);
      count <= count + CW'(wrVld) - CW'(rdRdy);
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: variable-latency memory model, queue-based reference model compared every cycle,
// plus hand-computed checkpoints for reset, first-fetch timing, stall, redirect, halt and PC wrap.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        nRst, stall, redirect, hlt, imRdy, imValid;
  logic [15:0] target, imData;
  logic        imReq, valid, halted;
  logic [15:0] imAddr, instr, pc, pcNext;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
    .i_clk(clk), .i_nRst(nRst), .i_stall(stall), .i_redirect(redirect),
    .i_target(target), .i_hlt(hlt), .o_imReq(imReq), .o_imAddr(imAddr),
    .i_imRdy(imRdy), .i_imValid(imValid), .i_imData(imData),
    .o_instr(instr), .o_pc(pc), .o_pcNext(pcNext), .o_valid(valid), .o_halted(halted)
  );

  typedef struct { logic [15:0] addr; int due; } memReq_t;
  typedef struct { logic [15:0] pc; bit stale; } tag_t;

  int          tests = 0, fails = 0, cycleCnt = 0, memLat = 1;
  bit          memRdy = 1'b1, haltArm = 1'b0;
  logic [15:0] haltPc = 16'h0000;
  memReq_t     pend[$];
  // Reference model: fetch PC, outstanding request tags, and the {instr,pc} words decode should see.
  logic [15:0] mFpc;
  tag_t        mTags[$];
  logic [31:0] mQ[$];
  bit          mHalted;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    nRst = 1'b0; stall = 1'b0; redirect = 1'b0; hlt = 1'b0; target = 16'h0;
    imValid = 1'b0; imData = 16'h0; imRdy = 1'b1;
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_pcNext", pcNext, 16'h0001);
    check("rst_imReq", imReq, 1'b0);
    check("rst_halted", halted, 1'b0);
    mFpc = 16'h0000; mTags.delete(); mQ.delete(); mHalted = 1'b0; pend.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 nRst = 1'b1;
    cycleCnt = 0;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance model and memory.
  task automatic cyc(input bit s, input bit r, input logic [15:0] t, input bit h);
    bit          expValid, expReq, issue, consume, haltNow, keep;
    logic [31:0] hd, newEnt;
    tag_t        tg;
    @(negedge clk);
    stall = s; redirect = r; target = t; imRdy = memRdy;
    imValid = (pend.size() > 0) && (pend[0].due <= cycleCnt);
    imData  = imValid ? pend[0].addr + 16'h1000 : 16'h0000;
    #1;
    hlt = h | (haltArm && valid && pc == haltPc);
    #1;
    expValid = mQ.size() > 0;
    expReq   = !mHalted && !r && (mQ.size() + mTags.size() < 2);
    check("valid", valid, expValid);
    if (expValid) begin
      hd = mQ[0];
      check("instr", instr, hd[31:16]);
      check("pc", pc, hd[15:0]);
      check("pcNext", pcNext, hd[15:0] + 16'd1);
    end
    check("imReq", imReq, expReq);
    if (expReq) check("imAddr", imAddr, mFpc);
    check("halted", halted, mHalted);

    issue   = expReq && imRdy;
    consume = expValid && !s;
    haltNow = hlt && expValid && !s && !r;
    keep    = 1'b0;
    newEnt  = '0;
    if (imValid && mTags.size() > 0) begin
      tg     = mTags.pop_front();
      keep   = !tg.stale && !mHalted && !r && !haltNow;
      newEnt = {tg.pc + 16'h1000, tg.pc};
    end
    if (r) begin
      mQ.delete();
      foreach (mTags[i]) mTags[i].stale = 1'b1;
      mFpc    = t;
      mHalted = 1'b0;
    end else begin
      if (consume) void'(mQ.pop_front());
      if (haltNow) begin
        mHalted = 1'b1;
        mQ.delete();
      end
      if (keep) mQ.push_back(newEnt);
    end
    if (issue) begin
      mTags.push_back('{mFpc, 1'b0});
      mFpc = mFpc + 16'd1;
    end

    if (imValid) void'(pend.pop_front());
    if (imReq && imRdy) pend.push_back('{imAddr, cycleCnt + memLat});
    cycleCnt++;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    do begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end while (!valid && n < 30);
    check(name, valid, 1'b1);
  endtask

  initial begin
    nRst = 1'b1; stall = 1'b0; redirect = 1'b0; hlt = 1'b0; target = 16'h0;
    imRdy = 1'b1; imValid = 1'b0; imData = 16'h0;
    doReset();

    // 1-cycle memory: first word visible in cycle 2, then credit-paced.
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    check("c2_valid", valid, 1'b1);
    check("c2_pc", pc, 16'h0000);
    check("c2_instr", instr, 16'h1000);
    cyc(0, 0, 16'h0, 0);
    check("c3_pc", pc, 16'h0001);
    check("c3_instr", instr, 16'h1001);
    cyc(0, 0, 16'h0, 0);
    check("c4_valid", valid, 1'b0);
    cyc(0, 0, 16'h0, 0);
    check("c5_pc", pc, 16'h0002);
    repeat (10) cyc(0, 0, 16'h0, 0);

    // Decode stall fills the queue and stops requests.
    repeat (5) cyc(1, 0, 16'h0, 0);
    check("stall_imReq", imReq, 1'b0);
    check("stall_valid", valid, 1'b1);
    repeat (6) cyc(0, 0, 16'h0, 0);

    // 3-cycle memory with ready gaps and occasional stalls.
    memLat = 3;
    for (int i = 0; i < 25; i++) begin
      memRdy = (i % 7 != 4);
      cyc((i % 6) == 5, 0, 16'h0, 0);
    end
    memRdy = 1'b1;

    // Redirect with two requests in flight and one response landing in the same cycle.
    begin
      bit found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        if (mTags.size() == 2 && pend.size() > 0 && pend[0].due <= cycleCnt) found = 1'b1;
        else cyc(0, 0, 16'h0, 0);
      end
      check("redir_setup", found, 1'b1);
    end
    cyc(0, 1, 16'h0040, 0);
    waitValid("redir_valid0");
    check("redir_pc0", pc, 16'h0040);
    waitValid("redir_valid1");
    check("redir_pc1", pc, 16'h0041);

    // Halt at PC 0007, then resume via redirect.
    memLat = 1;
    repeat (4) cyc(0, 0, 16'h0, 0);
    cyc(0, 1, 16'h0005, 0);
    haltArm = 1'b1; haltPc = 16'h0007;
    for (int i = 0; i < 30 && !hlt; i++) cyc(0, 0, 16'h0, 0);
    haltArm = 1'b0;
    check("halt_seen", hlt, 1'b1);
    cyc(0, 0, 16'h0, 0);
    check("halt_halted", halted, 1'b1);
    check("halt_valid", valid, 1'b0);
    check("halt_imReq", imReq, 1'b0);
    repeat (6) cyc(0, 0, 16'h0, 0);
    check("halt_imReq_late", imReq, 1'b0);
    cyc(0, 1, 16'h0010, 0);
    cyc(0, 0, 16'h0, 0);
    check("resume_halted", halted, 1'b0);
    waitValid("resume_valid");
    check("resume_pc", pc, 16'h0010);

    // Redirect and halt together: redirect wins.
    cyc(0, 1, 16'h0020, 1);
    cyc(0, 0, 16'h0, 0);
    check("both_halted", halted, 1'b0);
    waitValid("both_valid");
    check("both_pc", pc, 16'h0020);

    // PC wrap.
    cyc(0, 1, 16'hFFFF, 0);
    waitValid("wrap_valid0");
    check("wrap_pc0", pc, 16'hFFFF);
    check("wrap_pcNext", pcNext, 16'h0000);
    waitValid("wrap_valid1");
    check("wrap_pc1", pc, 16'h0000);

    // Reset with requests outstanding.
    memLat = 3;
    repeat (3) cyc(0, 0, 16'h0, 0);
    doReset();
    memLat = 1;
    repeat (3) cyc(0, 0, 16'h0, 0);
    check("rst2_valid", valid, 1'b1);
    check("rst2_pc", pc, 16'h0000);
    repeat (5) cyc(0, 0, 16'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
